// File: rtl/password_pkg.sv
// Shared types and constants for the password change controller.
package password_pkg;

   localparam int PW_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_VERIFY_OLD = 3'd1,
      ST_ENTER_NEW  = 3'd2,
      ST_CONFIRM    = 3'd3,
      ST_COMMIT     = 3'd4,
      ST_FAIL       = 3'd5,
      ST_LOCKOUT    = 3'd6
   } state_t;

   localparam logic [7:0] DISP_IDLE       = 8'h00;
   localparam logic [7:0] DISP_VERIFY_OLD = 8'h01;
   localparam logic [7:0] DISP_ENTER_NEW  = 8'h02;
   localparam logic [7:0] DISP_CONFIRM    = 8'h03;
   localparam logic [7:0] DISP_COMMIT     = 8'hC0;
   localparam logic [7:0] DISP_FAIL       = 8'hEE;
   localparam logic [7:0] DISP_LOCKOUT    = 8'hFF;

   // Status code shown on the 7-segment display for each state.
   function automatic logic [7:0] disp_of(input state_t s);
      case (s)
         ST_IDLE:       return DISP_IDLE;
         ST_VERIFY_OLD: return DISP_VERIFY_OLD;
         ST_ENTER_NEW:  return DISP_ENTER_NEW;
         ST_CONFIRM:    return DISP_CONFIRM;
         ST_COMMIT:     return DISP_COMMIT;
         ST_FAIL:       return DISP_FAIL;
         ST_LOCKOUT:    return DISP_LOCKOUT;
         default:       return DISP_IDLE;
      endcase
   endfunction

   // States where the user is typing and the inactivity timeout applies.
   function automatic logic is_entry(input state_t s);
      return (s == ST_VERIFY_OLD) || (s == ST_ENTER_NEW) || (s == ST_CONFIRM);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-FF synchroniser, stability counter, rising-edge pulse.
// A button held through reset is not reported until it has been seen released.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_a;
   logic             sync_b;
   logic [1:0]       fill;
   logic             level;
   logic             armed;
   logic [CNT_W-1:0] cnt;

   // Synchroniser; fill marks when sync_b carries real input rather than reset value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
         fill   <= 2'b00;
      end else begin
         sync_a <= btn_raw;
         sync_b <= sync_a;
         fill   <= {fill[0], 1'b1};
      end
   end

   // Level follows sync_b only after it differs for DEBOUNCE_CYCLES samples in a row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level <= 1'b0;
         armed <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         if (fill[1] && !sync_b) begin
            armed <= 1'b1;
         end
         if (sync_b == level) begin
            cnt <= CNT_LOAD;
         end else if (cnt == '0) begin
            level <= sync_b;
            press <= sync_b & armed;
            cnt   <= CNT_LOAD;
         end else begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/password_change_ctrl.sv
// Password change sequencer: verify old, enter new, confirm, commit.
//
// state         | meaning
// --------------+------------------------------------------------------
// ST_IDLE       | waiting for a press to start a change
// ST_VERIFY_OLD | next press must present the current password
// ST_ENTER_NEW  | next press captures the candidate password
// ST_CONFIRM    | next press must repeat the candidate
// ST_COMMIT     | single cycle: candidate written to stored_pw
// ST_FAIL       | wrong entry, held for FAIL_HOLD_CYCLES
// ST_LOCKOUT    | third consecutive failure, held for LOCK_CYCLES
module password_change_ctrl
   import password_pkg::*;
#(
   parameter logic [PW_W-1:0] DEFAULT_PW       = 4'h0,
   parameter int unsigned     DEBOUNCE_CYCLES  = 1_000_000,
   parameter int unsigned     TIMEOUT_CYCLES   = 500_000_000,
   parameter int unsigned     FAIL_HOLD_CYCLES = 100_000_000,
   parameter int unsigned     LOCK_CYCLES      = 1_000_000_000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            btn_set,
   input  logic [PW_W-1:0] sw_in,
   output logic [PW_W-1:0] stored_pw,
   output logic [7:0]      disp_code,
   output logic            busy,
   output logic            done,
   output logic            error
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam int FH_W = $clog2(FAIL_HOLD_CYCLES) + 1;
   localparam int LK_W = $clog2(LOCK_CYCLES) + 1;
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [FH_W-1:0] FH_LOAD = FH_W'(FAIL_HOLD_CYCLES - 1);
   localparam logic [LK_W-1:0] LK_LOAD = LK_W'(LOCK_CYCLES - 1);

   state_t            state;
   state_t            state_nxt;
   logic              press;
   logic              fail_evt;
   logic [PW_W-1:0]   new_tmp;
   logic [1:0]        fail_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic [FH_W-1:0]   fh_cnt;
   logic [LK_W-1:0]   lk_cnt;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_set),
      .press   (press)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; a press always takes priority over a timeout expiry.
   always_comb begin
      state_nxt = state;
      fail_evt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (press) state_nxt = ST_VERIFY_OLD;
         end
         ST_VERIFY_OLD: begin
            if (press) begin
               if (sw_in == stored_pw) state_nxt = ST_ENTER_NEW;
               else                    fail_evt  = 1'b1;
            end else if (to_cnt == '0) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_ENTER_NEW: begin
            if (press)              state_nxt = ST_CONFIRM;
            else if (to_cnt == '0)  state_nxt = ST_IDLE;
         end
         ST_CONFIRM: begin
            if (press) begin
               if (sw_in == new_tmp) state_nxt = ST_COMMIT;
               else                  fail_evt  = 1'b1;
            end else if (to_cnt == '0) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_COMMIT: begin
            state_nxt = ST_IDLE;
         end
         ST_FAIL: begin
            if (fh_cnt == '0) state_nxt = ST_IDLE;
         end
         ST_LOCKOUT: begin
            if (lk_cnt == '0) state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
      if (fail_evt) begin
         state_nxt = (fail_cnt == 2'd2) ? ST_LOCKOUT : ST_FAIL;
      end
   end

   // Status outputs decoded from the current state only.
   always_comb begin
      disp_code = disp_of(state);
      busy      = (state != ST_IDLE);
      done      = (state == ST_COMMIT);
      error     = (state == ST_FAIL) || (state == ST_LOCKOUT);
   end

   // Password registers and consecutive-failure counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stored_pw <= DEFAULT_PW;
         new_tmp   <= '0;
         fail_cnt  <= 2'd0;
      end else begin
         if (state == ST_ENTER_NEW && press) begin
            new_tmp <= sw_in;
         end
         if (state == ST_COMMIT) begin
            stored_pw <= new_tmp;
            fail_cnt  <= 2'd0;
         end else if (fail_evt) begin
            fail_cnt <= fail_cnt + 2'd1;
         end else if (state == ST_LOCKOUT && state_nxt == ST_IDLE) begin
            fail_cnt <= 2'd0;
         end
      end
   end

   // Saturating down-counters: inactivity timeout, fail hold, lockout hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt <= '0;
         fh_cnt <= '0;
         lk_cnt <= '0;
      end else begin
         if (is_entry(state_nxt) && (state_nxt != state || press)) begin
            to_cnt <= TO_LOAD;
         end else if (to_cnt != '0) begin
            to_cnt <= to_cnt - TO_W'(1);
         end

         if (state_nxt == ST_FAIL && state != ST_FAIL) begin
            fh_cnt <= FH_LOAD;
         end else if (fh_cnt != '0) begin
            fh_cnt <= fh_cnt - FH_W'(1);
         end

         if (state_nxt == ST_LOCKOUT && state != ST_LOCKOUT) begin
            lk_cnt <= LK_LOAD;
         end else if (lk_cnt != '0) begin
            lk_cnt <= lk_cnt - LK_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_password_change_ctrl.sv
// Bench for password_change_ctrl with small timing parameters.
module tb_password_change_ctrl;

   localparam int DEB = 4;
   localparam int TMO = 50;
   localparam int FH  = 8;
   localparam int LK  = 40;

   // Bench-side state names for the reference model.
   localparam int S_IDLE = 0, S_VER = 1, S_NEW = 2, S_CONF = 3, S_COM = 4, S_FAIL = 5, S_LOCK = 6, S_BAD = 7;

   logic       clk;
   logic       rst_n;
   logic       btn_set;
   logic [3:0] sw_in;
   logic [3:0] stored_pw;
   logic [7:0] disp_code;
   logic       busy;
   logic       done;
   logic       error;

   int total;
   int bad;

   int         m_st;
   int         m_age;
   int         m_fails;
   logic [3:0] m_pw;
   logic [3:0] m_new;
   logic [7:0] disp_tab [7];

   typedef struct {
      int         gap;
      logic [3:0] sw;
      logic [7:0] disp;
      logic [3:0] pw;
      logic       dn;
      logic       er;
   } vec_t;

   vec_t vt [21];

   password_change_ctrl #(
      .DEFAULT_PW       (4'h0),
      .DEBOUNCE_CYCLES  (DEB),
      .TIMEOUT_CYCLES   (TMO),
      .FAIL_HOLD_CYCLES (FH),
      .LOCK_CYCLES      (LK)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_set   (btn_set),
      .sw_in     (sw_in),
      .stored_pw (stored_pw),
      .disp_code (disp_code),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_st    = S_IDLE;
      m_age   = 0;
      m_fails = 0;
      m_pw    = 4'h0;
      m_new   = 4'h0;
   endtask

   // One clock of the password rules, given whether a debounced press lands now.
   task automatic model_step(input logic p, input logic [3:0] s);
      int age;
      int nx;
      age = m_age + 1;
      nx  = m_st;
      case (m_st)
         S_IDLE: if (p) nx = S_VER;
         S_VER: begin
            if (p) nx = (s == m_pw) ? S_NEW : S_BAD;
            else if (age >= TMO) nx = S_IDLE;
         end
         S_NEW: begin
            if (p) begin m_new = s; nx = S_CONF; end
            else if (age >= TMO) nx = S_IDLE;
         end
         S_CONF: begin
            if (p) nx = (s == m_new) ? S_COM : S_BAD;
            else if (age >= TMO) nx = S_IDLE;
         end
         S_COM: begin m_pw = m_new; m_fails = 0; nx = S_IDLE; end
         S_FAIL: if (age >= FH) nx = S_IDLE;
         S_LOCK: if (age >= LK) begin m_fails = 0; nx = S_IDLE; end
         default: nx = S_IDLE;
      endcase
      if (nx == S_BAD) begin
         m_fails++;
         nx = (m_fails >= 3) ? S_LOCK : S_FAIL;
      end
      m_age = (nx != m_st) ? 0 : age;
      m_st  = nx;
   endtask

   task automatic cmp_model();
      logic [14:0] exp;
      exp = {m_pw, disp_tab[m_st], m_st != S_IDLE, m_st == S_COM, (m_st == S_FAIL) || (m_st == S_LOCK)};
      chk("cycle", {17'd0, stored_pw, disp_code, busy, done, error}, {17'd0, exp});
   endtask

   // Drive inputs at the falling edge, step the model at the rising edge, compare at the next falling edge.
   task automatic cyc(input logic b, input logic [3:0] s, input logic p);
      btn_set = b;
      sw_in   = s;
      @(posedge clk);
      model_step(p, s);
      @(negedge clk);
      cmp_model();
   endtask

   // Clean press: 2 sync + DEB stable samples + registered pulse puts the transition on the 7th edge.
   task automatic press_hold(input logic [3:0] s);
      for (int i = 0; i < 7; i++) cyc(1'b1, s, i == 6);
   endtask

   task automatic release_btn();
      for (int i = 0; i < 7; i++) cyc(1'b0, sw_in, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, sw_in, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] s;
      logic       b;
      total = 0;
      bad   = 0;
      disp_tab = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hC0, 8'hEE, 8'hFF};

      //         gap  sw     disp   pw    done  err
      vt[0]  = '{0,  4'h0, 8'h01, 4'h0, 1'b0, 1'b0};
      vt[1]  = '{0,  4'h0, 8'h02, 4'h0, 1'b0, 1'b0};
      vt[2]  = '{0,  4'hA, 8'h03, 4'h0, 1'b0, 1'b0};
      vt[3]  = '{0,  4'hA, 8'hC0, 4'h0, 1'b1, 1'b0};
      vt[4]  = '{0,  4'h3, 8'h01, 4'hA, 1'b0, 1'b0};
      vt[5]  = '{0,  4'h3, 8'hEE, 4'hA, 1'b0, 1'b1};
      vt[6]  = '{2,  4'h0, 8'h01, 4'hA, 1'b0, 1'b0};
      vt[7]  = '{0,  4'hA, 8'h02, 4'hA, 1'b0, 1'b0};
      vt[8]  = '{0,  4'h5, 8'h03, 4'hA, 1'b0, 1'b0};
      vt[9]  = '{0,  4'h6, 8'hEE, 4'hA, 1'b0, 1'b1};
      vt[10] = '{2,  4'h0, 8'h01, 4'hA, 1'b0, 1'b0};
      vt[11] = '{0,  4'hF, 8'hFF, 4'hA, 1'b0, 1'b1};
      vt[12] = '{0,  4'h0, 8'hFF, 4'hA, 1'b0, 1'b1};
      vt[13] = '{30, 4'h0, 8'h01, 4'hA, 1'b0, 1'b0};
      vt[14] = '{0,  4'hA, 8'h02, 4'hA, 1'b0, 1'b0};
      vt[15] = '{0,  4'h1, 8'h03, 4'hA, 1'b0, 1'b0};
      vt[16] = '{0,  4'h2, 8'hEE, 4'hA, 1'b0, 1'b1};
      vt[17] = '{2,  4'hA, 8'h01, 4'hA, 1'b0, 1'b0};
      vt[18] = '{0,  4'hA, 8'h02, 4'hA, 1'b0, 1'b0};
      vt[19] = '{0,  4'hA, 8'h03, 4'hA, 1'b0, 1'b0};
      vt[20] = '{0,  4'hA, 8'hC0, 4'hA, 1'b1, 1'b0};

      rst_n   = 1'b0;
      btn_set = 1'b0;
      sw_in   = 4'h0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("rst_disp", {24'd0, disp_code}, 32'h00);
      chk("rst_pw", {28'd0, stored_pw}, 32'h0);
      chk("rst_flags", {29'd0, busy, done, error}, 32'h0);
      rst_n = 1'b1;
      idle(5);

      for (int i = 0; i < 21; i++) begin
         idle(vt[i].gap);
         press_hold(vt[i].sw);
         chk($sformatf("vec%0d_disp", i), {24'd0, disp_code}, {24'd0, vt[i].disp});
         chk($sformatf("vec%0d_pw", i), {28'd0, stored_pw}, {28'd0, vt[i].pw});
         chk($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, vt[i].dn});
         chk($sformatf("vec%0d_err", i), {31'd0, error}, {31'd0, vt[i].er});
         release_btn();
      end

      // Inactivity timeout in ENTER_NEW returns to IDLE after exactly TMO cycles.
      press_hold(4'h0);
      release_btn();
      press_hold(4'hA);
      release_btn();
      idle(TMO - 8);
      chk("timeout_before", {24'd0, disp_code}, 32'h02);
      idle(1);
      chk("timeout_expire", {24'd0, disp_code}, 32'h00);
      chk("timeout_pw", {28'd0, stored_pw}, 32'hA);

      // A press landing on the expiry cycle wins over the timeout.
      press_hold(4'h0);
      release_btn();
      press_hold(4'hA);
      release_btn();
      idle(TMO - 14);
      press_hold(4'h7);
      chk("press_wins", {24'd0, disp_code}, 32'h03);
      release_btn();

      // Asynchronous reset during CONFIRM clears outputs before the next edge.
      #2 rst_n = 1'b0;
      #1;
      chk("arst_disp", {24'd0, disp_code}, 32'h00);
      chk("arst_pw", {28'd0, stored_pw}, 32'h0);
      chk("arst_flags", {29'd0, busy, done, error}, 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      idle(5);

      // Button held through reset must not produce a press.
      btn_set = 1'b1;
      rst_n   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 20; i++) cyc(1'b1, 4'h0, 1'b0);
      chk("held_reset", {24'd0, disp_code}, 32'h00);
      release_btn();

      // Bouncing input: toggles every 2 cycles for 20 cycles, then stays high.
      for (int i = 0; i < 27; i++) begin
         b = (i >= 20) ? 1'b1 : ((i % 4) < 2);
         cyc(b, 4'h0, i == 26);
      end
      for (int i = 0; i < 30; i++) cyc(1'b1, 4'h0, 1'b0);
      chk("bounce_one", {24'd0, disp_code}, 32'h01);
      release_btn();

      // Randomised sessions checked cycle by cycle against the model.
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 9) == 0) idle($urandom_range(TMO - 5, TMO + 10));
         else                           idle($urandom_range(0, 4));
         if ($urandom_range(0, 2) != 0) s = (m_st == S_CONF) ? m_new : m_pw;
         else                           s = 4'($urandom_range(0, 15));
         press_hold(s);
         release_btn();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
